// File: rtl/vga_timing_gen.sv
// Raster timing generator and pixel output stage for a VGA port.
// Latency: fetch outputs are combinational from the counters; all others lag by DATA_LAT+1 cycles.
// Backpressure: none; frame-buffer data is taken on every cycle it is sampled.
//
// Ports:
//   i_pclk        pixel clock, all logic on the rising edge
//   i_reset       synchronous active-high reset
//   i_vga_data    {r,g,b} read data for the address issued DATA_LAT cycles earlier
//   o_h_addr      column being fetched (0 outside the active region)
//   o_v_addr      row being fetched (0 outside the active region)
//   o_addr_valid  fetch position is inside the active region
//   o_hsync       horizontal sync, active level HS_POL
//   o_vsync       vertical sync, active level VS_POL
//   o_valid       output pixel is visible
//   o_vga_r/g/b   colour outputs, forced to 0 when o_valid is low
//   o_line_start  one-cycle pulse on the first pixel slot of every line
//   o_frame_start one-cycle pulse on the first pixel slot of line 0
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_LAT = 1,
  parameter int CW       = 4,
  parameter int AW       = 10
) (
  input  logic            i_pclk,
  input  logic            i_reset,
  input  logic [3*CW-1:0] i_vga_data,
  output logic [AW-1:0]   o_h_addr,
  output logic [AW-1:0]   o_v_addr,
  output logic            o_addr_valid,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_valid,
  output logic [CW-1:0]   o_vga_r,
  output logic [CW-1:0]   o_vga_g,
  output logic [CW-1:0]   o_vga_b,
  output logic            o_line_start,
  output logic            o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int L       = DATA_LAT + 1;

  // Every boundary is strictly below the total, so all fit in the counter width.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (DATA_LAT < 0 || DATA_LAT > 4) begin : g_err_lat
    $error("vga_timing_gen: DATA_LAT must be in 0..4");
  end
  if (H_ACTIVE > 2**AW || V_ACTIVE > 2**AW) begin : g_err_aw
    $error("vga_timing_gen: active region does not fit in AW address bits");
  end
  if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_err_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic [HW-1:0]   r_x;
  logic [VW-1:0]   r_y;
  logic [L-1:0]    r_vld_p;
  logic [L-1:0]    r_hs_p;
  logic [L-1:0]    r_vs_p;
  logic [L-1:0]    r_ls_p;
  logic [L-1:0]    r_fs_p;
  logic [3*CW-1:0] r_rgb;

  logic w_addr_valid;
  logic w_hs_lvl;
  logic w_vs_lvl;
  logic w_line_first;
  logic w_frame_first;
  logic [L-1:0] w_vld_n;
  logic [L-1:0] w_hs_n;
  logic [L-1:0] w_vs_n;
  logic [L-1:0] w_ls_n;
  logic [L-1:0] w_fs_n;

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == H_LAST) begin
      r_x <= '0;
      r_y <= (r_y == V_LAST) ? '0 : r_y + VW'(1);
    end else begin
      r_x <= r_x + HW'(1);
    end
  end

  assign w_addr_valid = (r_x < H_ACT_END) && (r_y < V_ACT_END);
  assign o_addr_valid = w_addr_valid;
  assign o_h_addr     = w_addr_valid ? AW'(r_x) : '0;
  assign o_v_addr     = w_addr_valid ? AW'(r_y) : '0;

  // Sync levels are formed before the pipeline so the outputs come straight from flops.
  assign w_hs_lvl      = ((r_x >= H_SYNC_BEG) && (r_x < H_SYNC_END)) ? HS_POL : ~HS_POL;
  assign w_vs_lvl      = ((r_y >= V_SYNC_BEG) && (r_y < V_SYNC_END)) ? VS_POL : ~VS_POL;
  assign w_line_first  = (r_x == '0);
  assign w_frame_first = w_line_first && (r_y == '0);

  // Next pipeline contents: stage k loads stage k-1, stage 0 loads the fresh value.
  // The cast drops the old last stage, which has already been presented.
  assign w_vld_n = L'({r_vld_p, w_addr_valid});
  assign w_hs_n  = L'({r_hs_p, w_hs_lvl});
  assign w_vs_n  = L'({r_vs_p, w_vs_lvl});
  assign w_ls_n  = L'({r_ls_p, w_line_first});
  assign w_fs_n  = L'({r_fs_p, w_frame_first});

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_vld_p <= '0;
      r_hs_p  <= {L{~HS_POL}};
      r_vs_p  <= {L{~VS_POL}};
      r_ls_p  <= '0;
      r_fs_p  <= '0;
      r_rgb   <= '0;
    end else begin
      r_vld_p <= w_vld_n;
      r_hs_p  <= w_hs_n;
      r_vs_p  <= w_vs_n;
      r_ls_p  <= w_ls_n;
      r_fs_p  <= w_fs_n;
      // Read data for the pixel entering the last stage arrives on this very edge.
      r_rgb   <= w_vld_n[L-1] ? i_vga_data : '0;
    end
  end

  assign o_valid       = r_vld_p[L-1];
  assign o_hsync       = r_hs_p[L-1];
  assign o_vsync       = r_vs_p[L-1];
  assign o_line_start  = r_ls_p[L-1];
  assign o_frame_start = r_fs_p[L-1];
  assign o_vga_r       = r_rgb[3*CW-1:2*CW];
  assign o_vga_g       = r_rgb[2*CW-1:CW];
  assign o_vga_b       = r_rgb[CW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Default 640x480 timing, DATA_LAT=1
  logic        d_rst;
  logic [11:0] d_data;
  logic [9:0]  d_ha, d_va;
  logic        d_av, d_hs, d_vs, d_vld, d_ls, d_fs;
  logic [3:0]  d_r, d_g, d_b;

  vga_timing_gen u_def (
    .i_pclk(clk), .i_reset(d_rst), .i_vga_data(d_data),
    .o_h_addr(d_ha), .o_v_addr(d_va), .o_addr_valid(d_av),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_valid(d_vld),
    .o_vga_r(d_r), .o_vga_g(d_g), .o_vga_b(d_b),
    .o_line_start(d_ls), .o_frame_start(d_fs));

  always @(posedge clk) d_data <= {d_ha[3:0], d_va[3:0], 4'hA};

  // Small timing H 8/2/3/2, V 5/1/2/1, DATA_LAT=0 (combinational memory)
  logic        a_rst;
  logic [11:0] a_data;
  logic [3:0]  a_ha, a_va;
  logic        a_av, a_hs, a_vs, a_vld, a_ls, a_fs;
  logic [3:0]  a_r, a_g, a_b;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .DATA_LAT(0), .AW(4)) u_l0 (
    .i_pclk(clk), .i_reset(a_rst), .i_vga_data(a_data),
    .o_h_addr(a_ha), .o_v_addr(a_va), .o_addr_valid(a_av),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_valid(a_vld),
    .o_vga_r(a_r), .o_vga_g(a_g), .o_vga_b(a_b),
    .o_line_start(a_ls), .o_frame_start(a_fs));

  assign a_data = {a_ha, a_va, 4'hA};

  // Same small timing, DATA_LAT=3, active-high syncs
  logic        b_rst;
  logic [11:0] b_m1, b_m2, b_m3;
  logic [3:0]  b_ha, b_va;
  logic        b_av, b_hs, b_vs, b_vld, b_ls, b_fs;
  logic [3:0]  b_r, b_g, b_b;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .DATA_LAT(3), .AW(4)) u_l3 (
    .i_pclk(clk), .i_reset(b_rst), .i_vga_data(b_m3),
    .o_h_addr(b_ha), .o_v_addr(b_va), .o_addr_valid(b_av),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_valid(b_vld),
    .o_vga_r(b_r), .o_vga_g(b_g), .o_vga_b(b_b),
    .o_line_start(b_ls), .o_frame_start(b_fs));

  always @(posedge clk) begin
    b_m1 <= {b_ha, b_va, 4'hA};
    b_m2 <= b_m1;
    b_m3 <= b_m2;
  end

  // Tiny timing H 4/1/1/1, V 3/1/1/1, AW=3, DATA_LAT=1
  logic        t_rst;
  logic [11:0] t_data;
  logic [2:0]  t_ha, t_va;
  logic        t_av, t_hs, t_vs, t_vld, t_ls, t_fs;
  logic [3:0]  t_r, t_g, t_b;

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .DATA_LAT(1), .AW(3)) u_tiny (
    .i_pclk(clk), .i_reset(t_rst), .i_vga_data(t_data),
    .o_h_addr(t_ha), .o_v_addr(t_va), .o_addr_valid(t_av),
    .o_hsync(t_hs), .o_vsync(t_vs), .o_valid(t_vld),
    .o_vga_r(t_r), .o_vga_g(t_g), .o_vga_b(t_b),
    .o_line_start(t_ls), .o_frame_start(t_fs));

  always @(posedge clk) t_data <= {1'b0, t_ha, 1'b0, t_va, 4'hA};

  // Expected outputs k cycles after reset release (k=0: counters at 0,0).
  // Output stage shows pixel n = k-(lat+1); before that it shows idle levels.
  function automatic void exp_pixel(
      input int k, input int lat,
      input int ha, input int hf, input int hsw, input int hb,
      input int va, input int vf, input int vsw, input int vb,
      input bit hp, input bit vp,
      output bit av, output int fx, output int fy,
      output bit vld, output bit hsl, output bit vsl,
      output bit ls, output bit fs, output logic [11:0] rgb);
    int ht, vt, x, y, n, ox, oy;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    x  = k % ht;
    y  = (k / ht) % vt;
    av = (x < ha) && (y < va);
    fx = av ? x : 0;
    fy = av ? y : 0;
    n  = k - (lat + 1);
    if (n < 0) begin
      vld = 1'b0; hsl = !hp; vsl = !vp; ls = 1'b0; fs = 1'b0; rgb = 12'h0;
    end else begin
      ox  = n % ht;
      oy  = (n / ht) % vt;
      vld = (ox < ha) && (oy < va);
      hsl = (ox >= ha + hf && ox < ha + hf + hsw) ? hp : !hp;
      vsl = (oy >= va + vf && oy < va + vf + vsw) ? vp : !vp;
      ls  = (ox == 0);
      fs  = (ox == 0) && (oy == 0);
      rgb = vld ? {4'(ox), 4'(oy), 4'hA} : 12'h0;
    end
  endfunction

  task automatic test_reset();
    n_cmp++;
    if ({d_av, d_ha, d_va, d_vld, d_hs, d_vs, d_ls, d_fs, d_r, d_g, d_b} !==
        {1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0}) begin
      n_err++;
      $display("FAIL def_reset got=%h exp=%h",
               {d_av, d_ha, d_va, d_vld, d_hs, d_vs, d_ls, d_fs, d_r, d_g, d_b},
               {1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0});
    end
    n_cmp++;
    if ({b_av, b_ha, b_va, b_vld, b_hs, b_vs, b_ls, b_fs, b_r, b_g, b_b} !==
        {1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0}) begin
      n_err++;
      $display("FAIL pol_reset got=%h exp=%h",
               {b_av, b_ha, b_va, b_vld, b_hs, b_vs, b_ls, b_fs, b_r, b_g, b_b},
               {1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0});
    end
    n_cmp++;
    if ({t_av, t_ha, t_va, t_vld, t_hs, t_vs, t_ls, t_fs, t_r, t_g, t_b} !==
        {1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0}) begin
      n_err++;
      $display("FAIL tiny_reset got=%h exp=%h",
               {t_av, t_ha, t_va, t_vld, t_hs, t_vs, t_ls, t_fs, t_r, t_g, t_b},
               {1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0});
    end
  endtask

  task automatic test_default_line();
    logic [37:0] obs, expv;
    bit av, vld, hs, vs, ls, fs;
    int fx, fy;
    logic [11:0] rgb;
    int vld_rise = -1, vld_fall = -1, ls_at = -1, hs_lo = -1, hs_hi = -1;
    d_rst = 1'b0;
    for (int k = 0; k < 1700; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_pixel(k, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                av, fx, fy, vld, hs, vs, ls, fs, rgb);
      obs  = {d_av, d_ha, d_va, d_vld, d_hs, d_vs, d_ls, d_fs, d_r, d_g, d_b};
      expv = {av, 10'(fx), 10'(fy), vld, hs, vs, ls, fs, rgb};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL def_cycle k=%0d got=%h exp=%h", k, obs, expv);
      end
      if (d_vld === 1'b1 && vld_rise < 0) vld_rise = k;
      if (d_vld === 1'b0 && vld_rise >= 0 && vld_fall < 0) vld_fall = k;
      if (d_ls === 1'b1 && ls_at < 0) ls_at = k;
      if (d_hs === 1'b0 && hs_lo < 0) hs_lo = k;
      if (d_hs === 1'b1 && hs_lo >= 0 && hs_hi < 0) hs_hi = k;
    end
    n_cmp++;
    if (vld_rise != 2) begin
      n_err++; $display("FAIL def_valid_rise got=%0d exp=2", vld_rise);
    end
    n_cmp++;
    if (vld_fall - vld_rise != 640) begin
      n_err++; $display("FAIL def_valid_len got=%0d exp=640", vld_fall - vld_rise);
    end
    n_cmp++;
    if (hs_lo - ls_at != 656) begin
      n_err++; $display("FAIL def_hsync_start got=%0d exp=656", hs_lo - ls_at);
    end
    n_cmp++;
    if (hs_hi - hs_lo != 96) begin
      n_err++; $display("FAIL def_hsync_len got=%0d exp=96", hs_hi - hs_lo);
    end
  endtask

  task automatic test_reset_midframe();
    d_rst = 1'b1;
    @(posedge clk); #1;
    d_rst = 1'b0;
    repeat (1100) @(posedge clk);
    #1;
    n_cmp++;
    if ({d_ha, d_va, d_vld} !== {10'd300, 10'd1, 1'b1}) begin
      n_err++;
      $display("FAIL mid_position got=%h exp=%h", {d_ha, d_va, d_vld}, {10'd300, 10'd1, 1'b1});
    end
    d_rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({d_ha, d_va, d_av, d_vld, d_hs, d_vs, d_ls, d_fs, d_r, d_g, d_b} !==
        {10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0}) begin
      n_err++;
      $display("FAIL mid_reset got=%h exp=%h",
               {d_ha, d_va, d_av, d_vld, d_hs, d_vs, d_ls, d_fs, d_r, d_g, d_b},
               {10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0});
    end
    d_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (d_fs !== (k == 2)) begin
        n_err++; $display("FAIL mid_frame_start k=%0d got=%b exp=%b", k, d_fs, (k == 2));
      end
    end
  endtask

  task automatic test_latency0();
    logic [25:0] obs, expv;
    bit av, vld, hs, vs, ls, fs;
    int fx, fy;
    logic [11:0] rgb;
    int fs1 = -1, fs2 = -1;
    a_rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_pixel(k, 0, 8, 2, 3, 2, 5, 1, 2, 1, 1'b0, 1'b0,
                av, fx, fy, vld, hs, vs, ls, fs, rgb);
      obs  = {a_av, a_ha, a_va, a_vld, a_hs, a_vs, a_ls, a_fs, a_r, a_g, a_b};
      expv = {av, 4'(fx), 4'(fy), vld, hs, vs, ls, fs, rgb};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL lat0_cycle k=%0d got=%h exp=%h", k, obs, expv);
      end
      if (a_fs === 1'b1) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
    end
    n_cmp++;
    if (fs1 != 1 || fs2 - fs1 != 135) begin
      n_err++; $display("FAIL lat0_frame_period got=%0d,%0d exp=1,135", fs1, fs2 - fs1);
    end
  endtask

  task automatic test_latency3_polarity();
    logic [25:0] obs, expv;
    bit av, vld, hs, vs, ls, fs;
    int fx, fy;
    logic [11:0] rgb;
    int hs_hi = 0, vs_hi = 0;
    b_rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_pixel(k, 3, 8, 2, 3, 2, 5, 1, 2, 1, 1'b1, 1'b1,
                av, fx, fy, vld, hs, vs, ls, fs, rgb);
      obs  = {b_av, b_ha, b_va, b_vld, b_hs, b_vs, b_ls, b_fs, b_r, b_g, b_b};
      expv = {av, 4'(fx), 4'(fy), vld, hs, vs, ls, fs, rgb};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL lat3_cycle k=%0d got=%h exp=%h", k, obs, expv);
      end
      if (k >= 4 && k < 139) begin
        if (b_hs === 1'b1) hs_hi++;
        if (b_vs === 1'b1) vs_hi++;
      end
    end
    n_cmp++;
    if (hs_hi != 27) begin
      n_err++; $display("FAIL pol_hsync_high got=%0d exp=27", hs_hi);
    end
    n_cmp++;
    if (vs_hi != 30) begin
      n_err++; $display("FAIL pol_vsync_high got=%0d exp=30", vs_hi);
    end
  endtask

  task automatic test_tiny();
    logic [23:0] obs, expv;
    bit av, vld, hs, vs, ls, fs;
    int fx, fy;
    logic [11:0] rgb;
    int vld_cnt = 0, ls1 = -1, ls2 = -1, fs1 = -1, fs2 = -1;
    t_rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_pixel(k, 1, 4, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0,
                av, fx, fy, vld, hs, vs, ls, fs, rgb);
      obs  = {t_av, t_ha, t_va, t_vld, t_hs, t_vs, t_ls, t_fs, t_r, t_g, t_b};
      expv = {av, 3'(fx), 3'(fy), vld, hs, vs, ls, fs, rgb};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL tiny_cycle k=%0d got=%h exp=%h", k, obs, expv);
      end
      if (k >= 2 && k < 44 && t_vld === 1'b1) vld_cnt++;
      if (t_ls === 1'b1) begin
        if (ls1 < 0) ls1 = k;
        else if (ls2 < 0) ls2 = k;
      end
      if (t_fs === 1'b1) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
    end
    n_cmp++;
    if (vld_cnt != 12) begin
      n_err++; $display("FAIL tiny_valid_count got=%0d exp=12", vld_cnt);
    end
    n_cmp++;
    if (ls2 - ls1 != 7) begin
      n_err++; $display("FAIL tiny_line_period got=%0d exp=7", ls2 - ls1);
    end
    n_cmp++;
    if (fs1 != 2 || fs2 - fs1 != 42) begin
      n_err++; $display("FAIL tiny_frame_period got=%0d,%0d exp=2,42", fs1, fs2 - fs1);
    end
  endtask

  initial begin
    d_rst = 1'b1;
    a_rst = 1'b1;
    b_rst = 1'b1;
    t_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_default_line();
    test_reset_midframe();
    test_latency0();
    test_latency3_polarity();
    test_tiny();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
